// File: rtl/usadd_pkg.sv
// Shared definitions for the unipolar stochastic adder scheduler: the FSM
// state type and the LFSR tap/seed constants used by the stream generator.
package usadd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Seed of the A-stream LFSR; the B-stream seed is the top bit alone.
    localparam int unsigned LFSR_SEED_A = 1;

    // Right-shifting Galois feedback masks for maximal-length LFSRs.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0E08;
            13:      return 32'h0000_1C80;
            14:      return 32'h0000_3802;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h0000_00B8;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_seed_b(input int unsigned width);
        return 32'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/usadd_sng.sv
// Stream number generator. Always holds the stream counter that times a
// job. Default build: rngA is the counter, rngB its bit reversal, which
// makes the result exact. With USADD_SCHED_LFSR_EN defined, rngA/rngB come
// from two maximal-length LFSRs reseeded on every clear.
module usadd_sng #(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                advance,
    output logic [BITWIDTH-1:0] rngA,
    output logic [BITWIDTH-1:0] rngB,
    output logic                last
);

    logic [BITWIDTH-1:0] cnt;

    // Stream counter: cleared on grant, steps once per RUN cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (clear)   cnt <= '0;
        else if (advance) cnt <= cnt + BITWIDTH'(1);
    end

    // The cycle that wraps the counter is the final RUN cycle.
    assign last = &cnt;

`ifdef USADD_SCHED_LFSR_EN
    import usadd_pkg::*;

    localparam logic [BITWIDTH-1:0] TAPS   = BITWIDTH'(lfsr_taps(BITWIDTH));
    localparam logic [BITWIDTH-1:0] SEED_A = BITWIDTH'(LFSR_SEED_A);
    localparam logic [BITWIDTH-1:0] SEED_B = BITWIDTH'(lfsr_seed_b(BITWIDTH));

    logic [BITWIDTH-1:0] lfsr_a;
    logic [BITWIDTH-1:0] lfsr_b;

    // LFSR pair: reseeded on grant, Galois step once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
        end else if (clear) begin
            lfsr_a <= SEED_A;
            lfsr_b <= SEED_B;
        end else if (advance) begin
            lfsr_a <= (lfsr_a >> 1) ^ (lfsr_a[0] ? TAPS : '0);
            lfsr_b <= (lfsr_b >> 1) ^ (lfsr_b[0] ? TAPS : '0);
        end
    end

    assign rngA = lfsr_a;
    assign rngB = lfsr_b;
`else
    // Counter and its bit reversal give low-discrepancy, exact streams.
    // NOTE: every output of a combinational block gets a default first so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        rngA = cnt;
        rngB = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            rngB[i] = cnt[BITWIDTH-1-i];
        end
    end
`endif

endmodule

// File: rtl/usadd_sched.sv
// Round-robin scheduler around a unipolar stochastic scaled adder. One job
// at a time: grant in IDLE, 2^BITWIDTH RUN cycles, one DRAIN cycle, then the
// result is held in DONE until the consumer takes it. Define
// USADD_SCHED_LFSR_EN to use LFSR stream sources (approximate result).
module usadd_sched
    import usadd_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int NREQ     = 4
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic [NREQ-1:0]          iReq,
    input  logic [NREQ*BITWIDTH-1:0] iA,
    input  logic [NREQ*BITWIDTH-1:0] iB,
    input  logic                     iReady,
    output logic [NREQ-1:0]          oGnt,
    output logic                     oBusy,
    output logic                     oValid,
    output logic [BITWIDTH-1:0]      oResult,
    output logic [$clog2(NREQ)-1:0]  oId
);

    localparam int IDW = $clog2(NREQ);

    state_t              state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      pick_idx;
    logic                pick_valid;
    logic                grant;
    logic [BITWIDTH-1:0] a_slot [NREQ];
    logic [BITWIDTH-1:0] b_slot [NREQ];
    logic [BITWIDTH-1:0] op_a, op_b;
    logic [BITWIDTH-1:0] rng_a, rng_b;
    logic [BITWIDTH-1:0] ones, ones_fin;
    logic [1:0]          acc;
    logic                bit_a, bit_b, last;

    // Round-robin pick: first requester at or after the pointer, circularly.
    always_comb begin
        int idx;
        logic [IDW-1:0] cand;
        idx        = 0;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx  = (int'(ptr) + i) % NREQ;
            cand = IDW'(idx);
            if (!pick_valid && iReq[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Unpack the per-requester operand slices.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            a_slot[k] = iA[k*BITWIDTH +: BITWIDTH];
            b_slot[k] = iB[k*BITWIDTH +: BITWIDTH];
        end
    end

    // The grant is decided and pulsed in the IDLE cycle whose closing edge
    // latches the operands; held low while reset is asserted.
    assign grant = (state == IDLE) && pick_valid;
    assign oGnt  = (grant && iRstN) ? (NREQ'(1) << pick_idx) : '0;

    // Operand capture on grant.
    // NOTE: plain datapath registers are left out of reset; they are always
    // written at grant before anything reads them.
    always_ff @(posedge iClk) begin
        if (grant) begin
            op_a <= a_slot[pick_idx];
            op_b <= b_slot[pick_idx];
        end
    end

    usadd_sng #(
        .BITWIDTH(BITWIDTH)
    ) u_sng (
        .clk    (iClk),
        .rst_n  (iRstN),
        .clear  (grant),
        .advance(state == RUN),
        .rngA   (rng_a),
        .rngB   (rng_b),
        .last   (last)
    );

    assign bit_a    = rng_a < op_a;
    assign bit_b    = rng_b < op_b;
    assign ones_fin = ones + BITWIDTH'(acc[1]);

    // Control FSM with the 2-bit scaled-adder accumulator and ones counter.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state   <= IDLE;
            ptr     <= '0;
            acc     <= '0;
            ones    <= '0;
            oBusy   <= 1'b0;
            oValid  <= 1'b0;
            oResult <= '0;
            oId     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state <= RUN;
                        oBusy <= 1'b1;
                        oId   <= pick_idx;
                        ptr   <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
                        acc   <= '0;
                        ones  <= '0;
                    end
                end
                RUN: begin
                    acc  <= 2'(acc[0]) + 2'(bit_a) + 2'(bit_b);
                    ones <= ones_fin;
                    if (last) state <= DRAIN;
                end
                DRAIN: begin
                    // Final carry counted; residual acc[0] is dropped.
                    acc     <= '0;
                    ones    <= ones_fin;
                    oResult <= ones_fin;
                    oValid  <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        oBusy  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usadd_sched.sv
// Directed plus randomized bench for usadd_sched (BITWIDTH=8, NREQ=4).
// Expected grants come from a round-robin model; expected results from
// floor((A+B)/2), with a +/-16 window when USADD_SCHED_LFSR_EN is defined.
module tb_usadd_sched;

    localparam int BW  = 8;
    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int LATENCY = (1 << BW) + 2;

    logic             clk = 1'b0;
    logic             iRstN;
    logic [NR-1:0]    iReq;
    logic [NR*BW-1:0] iA, iB;
    logic             iReady;
    logic [NR-1:0]    oGnt;
    logic             oBusy, oValid;
    logic [BW-1:0]    oResult;
    logic [IDW-1:0]   oId;

    int n_checks = 0;
    int n_pass   = 0;
    int model_ptr = 0;
    logic [BW-1:0] opa [NR];
    logic [BW-1:0] opb [NR];

    always #5 clk = ~clk;

    usadd_sched #(.BITWIDTH(BW), .NREQ(NR)) dut (
        .iClk   (clk),
        .iRstN  (iRstN),
        .iReq   (iReq),
        .iA     (iA),
        .iB     (iB),
        .iReady (iReady),
        .oGnt   (oGnt),
        .oBusy  (oBusy),
        .oValid (oValid),
        .oResult(oResult),
        .oId    (oId)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_result(input string tag, input logic [31:0] obs, input logic [31:0] exp);
`ifdef USADD_SCHED_LFSR_EN
        n_checks++;
        assert ((obs + 16 >= exp) && (obs <= exp + 16)) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d +/-16", tag, obs, exp);
`else
        check(tag, obs, exp);
`endif
    endtask

    task automatic drive_ops();
        for (int k = 0; k < NR; k++) begin
            iA[k*BW +: BW] = opa[k];
            iB[k*BW +: BW] = opb[k];
        end
    endtask

    // Round-robin reference: first requesting index at or after the pointer.
    function automatic int model_pick(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++) begin
            if (mask[(model_ptr + i) % NR]) return (model_ptr + i) % NR;
        end
        return 0;
    endfunction

    // One complete job, entered and left at a negedge in an IDLE cycle.
    task automatic run_job(input logic [NR-1:0] mask, input int hold,
                           input bit keep, input string tag);
        int exp_id, exp_res, c;
        bit stable, gnt_ok;
        logic [BW-1:0]  r;
        logic [IDW-1:0] id;
        iReq = mask;
        drive_ops();
        #1;
        exp_id  = model_pick(mask);
        exp_res = (int'(opa[exp_id]) + int'(opb[exp_id])) / 2;
        c = 0;
        while (oGnt == '0 && c < 8) begin
            @(negedge clk); #1; c++;
        end
        check({tag, "_gnt"}, 32'(oGnt), 32'(1) << exp_id);
        model_ptr = (exp_id + 1) % NR;
        gnt_ok = 1'b1;
        for (c = 1; c < 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!keep) iReq = mask & ~(NR'(1) << exp_id);
                iA = $urandom;
                iB = $urandom;
            end
            #1;
            if (oGnt != '0 || !oBusy) gnt_ok = 1'b0;
            if (oValid) break;
        end
        check({tag, "_quiet_run"}, 32'(gnt_ok), 1);
        check({tag, "_latency"}, c, LATENCY);
        check_result({tag, "_result"}, 32'(oResult), exp_res);
        check({tag, "_id"}, 32'(oId), exp_id);
        if (hold > 0) begin
            r = oResult;
            id = oId;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk); #1;
                if (!oValid || oResult !== r || oId !== id || oGnt != '0) stable = 1'b0;
            end
            check({tag, "_hold_stable"}, 32'(stable), 1);
        end
        iReady = 1'b1;
        @(negedge clk);
        iReady = 1'b0;
        #1;
        check({tag, "_idle_after_ack"}, {oBusy, oValid}, 0);
    endtask

    initial begin
        int c;
        iRstN = 1'b0; iReq = '0; iA = '0; iB = '0; iReady = 1'b0;
        for (int k = 0; k < NR; k++) begin
            opa[k] = '0;
            opb[k] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'({oGnt, oBusy, oValid, oResult, oId}), 0);
        @(negedge clk);
        iRstN = 1'b1;

        // Basic job on requester 0.
        opa[0] = 8'd100; opb[0] = 8'd50;
        run_job(4'b0001, 0, 1'b0, "basic");

        // Corner operands, spread so the pointer ends back at requester 0.
        opa[1] = 8'd255; opb[1] = 8'd255;
        run_job(4'b0010, 0, 1'b0, "max");
        opa[2] = 8'd0;   opb[2] = 8'd0;
        run_job(4'b0100, 0, 1'b0, "zero");
        opa[0] = 8'd1;   opb[0] = 8'd0;
        run_job(4'b0001, 0, 1'b0, "one_zero");
        opa[3] = 8'd1;   opb[3] = 8'd1;
        run_job(4'b1000, 0, 1'b0, "one_one");

        // All four requesting continuously: order 0,1,2,3,0.
        for (int k = 0; k < NR; k++) begin
            opa[k] = BW'(30 * k + 7);
            opb[k] = BW'(200 - 40 * k);
        end
        repeat (5) run_job(4'b1111, 0, 1'b1, "rr_all");

        // Consumer stalls for 10 cycles.
        opa[1] = 8'd10; opb[1] = 8'd20;
        run_job(4'b0010, 10, 1'b0, "stall");

        // Randomized operands, masks and consumer delays.
        repeat (6) begin
            for (int k = 0; k < NR; k++) begin
                opa[k] = BW'($urandom);
                opb[k] = BW'($urandom);
            end
            run_job(NR'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0, "rand");
        end

        // Reset in the middle of RUN discards the job.
        opa[0] = 8'd200; opb[0] = 8'd100;
        drive_ops();
        iReq = 4'b0001;
        #1;
        c = 0;
        while (oGnt == '0 && c < 8) begin
            @(negedge clk); #1; c++;
        end
        check("rst_job_gnt", 32'(oGnt), 32'(1) << model_pick(4'b0001));
        @(negedge clk);
        iReq = '0;
        repeat (99) @(negedge clk);
        iRstN = 1'b0;
        #1;
        check("mid_run_reset", 32'({oGnt, oBusy, oValid, oResult, oId}), 0);
        repeat (2) @(negedge clk);
        iRstN = 1'b1;
        model_ptr = 0;
        opa[1] = 8'd40; opb[1] = 8'd90;
        opa[3] = 8'd77; opb[3] = 8'd33;
        run_job(4'b1010, 0, 1'b0, "post_rst");
        run_job(4'b1000, 0, 1'b0, "post_rst_next");

        // Mid-scale operands (the approximate-mode tolerance case).
        opa[2] = 8'd128; opb[2] = 8'd128;
        run_job(4'b0100, 0, 1'b0, "mid_scale");

        iReq = '0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usadd_sched.md
USADD_SCHED -- requirements
Module: usadd_sched

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: operand and result width; stream length is 2^BITWIDTH.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, at least 2.
REQ-003 SHALL have port iClk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port iRstN, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port iReq, input, NREQ: per-requester level request, held until granted.
REQ-006 SHALL have port iA, input, NREQ*BITWIDTH: unipolar operand A; requester k occupies slice [k*BITWIDTH +: BITWIDTH].
REQ-007 SHALL have port iB, input, NREQ*BITWIDTH: operand B, same packing as iA.
REQ-008 SHALL have port oGnt, output, NREQ: one-hot, single-cycle pulse marking the cycle the operands are latched.
REQ-009 SHALL have port oBusy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port oValid, output, 1: result available.
REQ-011 SHALL have port oResult, output, BITWIDTH: count of adder output ones, i.e. the scaled sum (A+B)/2.
REQ-012 SHALL have port oId, output, clog2(NREQ): index of the requester that owns oResult.
REQ-013 SHALL have port iReady, input, 1: consumer accepts the result in any cycle where oValid and iReady are both high.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE with any iReq high SHALL do all of the following in that cycle, then go to RUN:
- pick a requester round-robin, starting at the index after the last grant;
- latch its A and B;
- pulse oGnt for that requester;
- clear the stream counter, the 2-bit adder accumulator and the ones counter.
REQ-016 In RUN, each cycle SHALL:
- generate bitA = (rngA < A) and bitB = (rngB < B);
- update acc <= acc[0] + bitA + bitB;
- add the registered acc[1] to the ones counter.
REQ-017 RUN SHALL last exactly 2^BITWIDTH cycles; stream counter wrap-around SHALL cause the transition to DRAIN.
REQ-018 DRAIN SHALL last one cycle, adding the final acc[1] with no new stream bits; the residual acc[0] SHALL be discarded.
REQ-019 For a grant in cycle T, oValid SHALL first be high in cycle T+2^BITWIDTH+2 (T+258 at BITWIDTH=8).
REQ-020 In DONE, oValid, oResult and oId SHALL stay stable until iReady is high; the handshake cycle SHALL return the FSM to IDLE, so a new grant occurs no earlier than the next cycle.
REQ-021 Ones-counter width SHALL be BITWIDTH; the maximum value floor((2^BITWIDTH-1)*2/2) never overflows.
REQ-022 iReq, iA and iB SHALL be ignored outside IDLE; a requester that deasserts before its grant SHALL lose its turn without stalling the FSM.
REQ-023 With simultaneous requests, each active requester SHALL be granted within NREQ jobs.

Reset
REQ-024 iRstN low SHALL immediately force the following, including mid-RUN or mid-DONE with the job discarded:
- state to IDLE;
- oGnt, oBusy, oValid, oResult and oId to 0;
- the round-robin pointer so that requester 0 has priority;
- the LFSRs to their seeds.

Configuration
REQ-025 Macro USADD_SCHED_LFSR_EN SHALL select the stream number source.
REQ-026 Without USADD_SCHED_LFSR_EN:
- rngA SHALL be the stream counter;
- rngB SHALL be the bit-reversed stream counter;
- the result SHALL be exactly floor((A+B)/2).
REQ-027 With USADD_SCHED_LFSR_EN:
- rngA and rngB SHALL be two maximal-length BITWIDTH-bit LFSRs, seeds 1 and 2^(BITWIDTH-1);
- both SHALL be reseeded on each grant;
- the result is approximate;
- latency SHALL be unchanged.

Structure
REQ-028 Shared package usadd_pkg SHALL hold the state enum typedef and the LFSR tap and seed constants.
REQ-029 Stream number generation, meaning the counter and bit-reverse or the LFSR pair, SHALL be sub-module usadd_sng, with inputs clear and advance and outputs rngA and rngB.

Verification
REQ-030 The bench SHALL cover these directed scenarios; scenarios 1-5 use the counter mode and BITWIDTH=8:
1. req0, A=100, B=50 -> oGnt[0] pulse at T, oValid at T+258, oResult=75, oId=0.
2. Corner operands:
   - A=255, B=255 -> 255;
   - A=0, B=0 -> 0;
   - A=1, B=0 -> 0;
   - A=1, B=1 -> 1.
3. iReq=4'b1111 held -> grant order 0,1,2,3,0; no requester granted twice before the others.
4. iReady low for 10 cycles after oValid -> oValid, oResult and oId stable, no oGnt; iReady high -> IDLE next cycle.
5. iRstN pulsed low at RUN cycle 100 -> all outputs 0 immediately; with iReq=4'b1010 afterwards, first grant goes to requester 1.
6. With USADD_SCHED_LFSR_EN, A=128, B=128 -> oResult within 128±16, latency still 258.
